// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end for a shared 4-bit combinational ALU.
// One operation in flight: IDLE accepts, EXEC drives the ALU, RESP holds the result until taken.
module alu_req_arbiter #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [2:0]        req0_op,
    input  logic [DATA_W-1:0] req0_x,
    input  logic [DATA_W-1:0] req0_y,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [2:0]        req1_op,
    input  logic [DATA_W-1:0] req1_x,
    input  logic [DATA_W-1:0] req1_y,
    output logic [2:0]        alu_select,
    output logic              alu_in_c,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    input  logic [DATA_W-1:0] alu_out_s,
    input  logic              alu_out_c,
    input  logic              alu_zero,
    input  logic              alu_overflow,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_s,
    output logic              rsp_c,
    output logic              rsp_zero,
    output logic              rsp_overflow,
    output logic              rsp_err,
    output logic [CNT_W-1:0]  done_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_RSB = 3'b110;
    localparam logic [2:0] OP_BAD = 3'b111;

    state_t              state_q;
    logic                rr_last_q;
    logic [2:0]          op_q;
    logic                id_q;
    logic [2:0]          alu_select_q;
    logic                alu_in_c_q;
    logic [DATA_W-1:0]   alu_x_q;
    logic [DATA_W-1:0]   alu_y_q;
    logic                rsp_valid_q;
    logic                rsp_id_q;
    logic [DATA_W-1:0]   rsp_s_q;
    logic                rsp_c_q;
    logic                rsp_zero_q;
    logic                rsp_overflow_q;
    logic                rsp_err_q;
    logic [CNT_W-1:0]    done_cnt_q;

    logic                grant_valid;
    logic                grant_id;
    logic [2:0]          sel_op;
    logic [DATA_W-1:0]   sel_x;
    logic [DATA_W-1:0]   sel_y;
    logic                rsp_zero_d;

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        grant_valid = req0_valid || req1_valid;
        grant_id    = (req0_valid && req1_valid) ? !rr_last_q : req1_valid;
        sel_op      = grant_id ? req1_op : req0_op;
        sel_x       = grant_id ? req1_x  : req0_x;
        sel_y       = grant_id ? req1_y  : req0_y;
    end

    // The ALU zero flag is only trusted for add/subtract; other ops derive it from the result.
    always_comb begin
        rsp_zero_d = (alu_out_s == '0);
        if (op_q == OP_ADD || op_q == OP_SUB) begin
            rsp_zero_d = alu_zero;
        end
    end

    assign req0_ready = (state_q == S_IDLE) && grant_valid && !grant_id;
    assign req1_ready = (state_q == S_IDLE) && grant_valid &&  grant_id;

    // NOTE: every register here, including the captured response, is cleared by the
    // synchronous reset so a discarded op can never leak stale data after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            rr_last_q      <= 1'b1;
            op_q           <= '0;
            id_q           <= 1'b0;
            alu_select_q   <= '0;
            alu_in_c_q     <= 1'b0;
            alu_x_q        <= '0;
            alu_y_q        <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_id_q       <= 1'b0;
            rsp_s_q        <= '0;
            rsp_c_q        <= 1'b0;
            rsp_zero_q     <= 1'b0;
            rsp_overflow_q <= 1'b0;
            rsp_err_q      <= 1'b0;
            done_cnt_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_valid) begin
                        op_q      <= sel_op;
                        id_q      <= grant_id;
                        rr_last_q <= grant_id;
                        state_q   <= S_EXEC;
                        if (sel_op != OP_BAD) begin
                            alu_select_q <= sel_op;
                            alu_in_c_q   <= (sel_op == OP_SUB) || (sel_op == OP_RSB);
                            alu_x_q      <= sel_x;
                            alu_y_q      <= sel_y;
                        end
                    end
                end
                S_EXEC: begin
                    rsp_id_q     <= id_q;
                    rsp_valid_q  <= 1'b1;
                    alu_select_q <= '0;
                    alu_in_c_q   <= 1'b0;
                    alu_x_q      <= '0;
                    alu_y_q      <= '0;
                    state_q      <= S_RESP;
                    if (op_q == OP_BAD) begin
                        rsp_s_q        <= '0;
                        rsp_c_q        <= 1'b0;
                        rsp_zero_q     <= 1'b1;
                        rsp_overflow_q <= 1'b0;
                        rsp_err_q      <= 1'b1;
                    end else begin
                        rsp_s_q        <= alu_out_s;
                        rsp_c_q        <= alu_out_c;
                        rsp_zero_q     <= rsp_zero_d;
                        rsp_overflow_q <= alu_overflow;
                        rsp_err_q      <= 1'b0;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                        if (done_cnt_q != '1) begin
                            done_cnt_q <= done_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign alu_select   = alu_select_q;
    assign alu_in_c     = alu_in_c_q;
    assign alu_x        = alu_x_q;
    assign alu_y        = alu_y_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_s        = rsp_s_q;
    assign rsp_c        = rsp_c_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_overflow = rsp_overflow_q;
    assign rsp_err      = rsp_err_q;
    assign done_cnt     = done_cnt_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: a behavioural ALU on the pins, an integer-arithmetic reference
// model feeding a scoreboard, and a negedge monitor that checks grants, ALU pins and responses.
module tb_alu_req_arbiter;

    localparam int DATA_W = 4;
    localparam int CNT_W  = 8;
    localparam int P_IDLE = 0;
    localparam int P_EXEC = 1;
    localparam int P_RESP = 2;

    logic              clk;
    logic              rst_n;
    logic              req0_valid, req1_valid;
    logic              req0_ready, req1_ready;
    logic [2:0]        req0_op, req1_op;
    logic [DATA_W-1:0] req0_x, req0_y, req1_x, req1_y;
    logic [2:0]        alu_select;
    logic              alu_in_c;
    logic [DATA_W-1:0] alu_x, alu_y;
    logic [DATA_W-1:0] alu_out_s;
    logic              alu_out_c, alu_zero, alu_overflow;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_s;
    logic              rsp_c, rsp_zero, rsp_overflow, rsp_err;
    logic [CNT_W-1:0]  done_cnt;

    alu_req_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_x(req0_x), .req0_y(req0_y),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_x(req1_x), .req1_y(req1_y),
        .alu_select(alu_select), .alu_in_c(alu_in_c), .alu_x(alu_x), .alu_y(alu_y),
        .alu_out_s(alu_out_s), .alu_out_c(alu_out_c), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_s(rsp_s),
        .rsp_c(rsp_c), .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
        .rsp_err(rsp_err), .done_cnt(done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: add, subtract (x+~y+in_c), reverse subtract (y+~x+in_c), logic ops.
    // Its zero flag is only driven for add/subtract, so the arbiter must derive the rest.
    logic [4:0] alu_sum;
    always_comb begin
        alu_sum      = 5'd0;
        alu_overflow = 1'b0;
        case (alu_select)
            3'b000: alu_sum = {1'b0, alu_x} + {1'b0, alu_y} + {4'd0, alu_in_c};
            3'b001: alu_sum = {1'b0, alu_x} + {1'b0, ~alu_y} + {4'd0, alu_in_c};
            3'b110: alu_sum = {1'b0, alu_y} + {1'b0, ~alu_x} + {4'd0, alu_in_c};
            3'b010: alu_sum = {1'b0, alu_x | alu_y};
            3'b011: alu_sum = {1'b0, alu_x & alu_y};
            3'b100: alu_sum = {1'b0, alu_x ^ alu_y};
            3'b101: alu_sum = {1'b0, ~(alu_x | alu_y)};
            default: alu_sum = {1'b0, alu_x};
        endcase
        alu_out_s = alu_sum[3:0];
        alu_out_c = (alu_select == 3'b000 || alu_select == 3'b001 || alu_select == 3'b110)
                    ? alu_sum[4] : 1'b0;
        case (alu_select)
            3'b000: alu_overflow = (alu_x[3] == alu_y[3]) && (alu_sum[3] != alu_x[3]);
            3'b001: alu_overflow = (alu_x[3] != alu_y[3]) && (alu_sum[3] != alu_x[3]);
            3'b110: alu_overflow = (alu_y[3] != alu_x[3]) && (alu_sum[3] != alu_y[3]);
            default: alu_overflow = 1'b0;
        endcase
        alu_zero = (alu_select == 3'b000 || alu_select == 3'b001) ? (alu_sum[3:0] == 4'd0) : 1'b0;
    end

    typedef struct {
        logic       id;
        logic [2:0] op;
        logic [3:0] x;
        logic [3:0] y;
        logic [3:0] s;
        logic       c;
        logic       zero;
        logic       ovf;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_ops    = 0;
    int   ref_cnt  = 0;
    int   phase    = P_IDLE;
    logic last_id  = 1'b1;
    int   rr_mode  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected result from the operation's meaning, using signed/unsigned integer arithmetic.
    function automatic exp_t ref_op(input logic id, input logic [2:0] op,
                                    input logic [3:0] x, input logic [3:0] y);
        exp_t e;
        int ux = int'(x);
        int uy = int'(y);
        int sx = (ux > 7) ? ux - 16 : ux;
        int sy = (uy > 7) ? uy - 16 : uy;
        int r  = 0;
        int sr = 0;
        e.id = id; e.op = op; e.x = x; e.y = y;
        e.s = 4'd0; e.c = 1'b0; e.zero = 1'b1; e.ovf = 1'b0; e.err = 1'b0;
        case (op)
            3'd0: begin r = ux + uy; sr = sx + sy; e.c = (r > 15);   end
            3'd1: begin r = ux - uy; sr = sx - sy; e.c = (ux >= uy); end
            3'd6: begin r = uy - ux; sr = sy - sx; e.c = (uy >= ux); end
            3'd2: r = int'(x | y);
            3'd3: r = int'(x & y);
            3'd4: r = int'(x ^ y);
            3'd5: r = int'(4'(~(x | y)));
            default: begin e.err = 1'b1; return e; end
        endcase
        e.s    = 4'((r + 16) % 16);
        e.ovf  = (op == 3'd0 || op == 3'd1 || op == 3'd6) && (sr > 7 || sr < -8);
        e.zero = (e.s == 4'd0);
        return e;
    endfunction

    // Monitor: checks what the DUT shows this cycle, then advances the model to the next cycle.
    always @(negedge clk) begin
        logic e0, e1;
        exp_t h;
        logic [11:0] pins_exp;
        if (!rst_n) begin
            sb.delete();
            phase   = P_IDLE;
            last_id = 1'b1;
            ref_cnt = 0;
        end else begin
            e0 = 1'b0;
            e1 = 1'b0;
            if (phase == P_IDLE) begin
                if (req0_valid && req1_valid) begin
                    e0 = last_id;
                    e1 = !last_id;
                end else begin
                    e0 = req0_valid;
                    e1 = req1_valid;
                end
            end
            check("req0_ready", 32'(req0_ready), 32'(e0));
            check("req1_ready", 32'(req1_ready), 32'(e1));
            check("ready_onehot", 32'(req0_ready && req1_ready), 32'd0);
            check("rsp_valid", 32'(rsp_valid), 32'(phase == P_RESP));
            check("done_cnt", 32'(done_cnt), 32'(ref_cnt));
            pins_exp = 12'd0;
            if (phase != P_IDLE) begin
                check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            end
            if (phase == P_EXEC && sb.size() != 0) begin
                h = sb[0];
                if (h.op != 3'b111) begin
                    pins_exp = {h.op, (h.op == 3'b001 || h.op == 3'b110), h.x, h.y};
                end
            end
            check("alu_pins", 32'({alu_select, alu_in_c, alu_x, alu_y}), 32'(pins_exp));
            if (phase == P_RESP && sb.size() != 0) begin
                h = sb[0];
                check("rsp_fields", 32'({rsp_id, rsp_s, rsp_c, rsp_zero, rsp_overflow, rsp_err}),
                      32'({h.id, h.s, h.c, h.zero, h.ovf, h.err}));
            end
            case (phase)
                P_IDLE: begin
                    if (req0_valid && req0_ready) begin
                        sb.push_back(ref_op(1'b0, req0_op, req0_x, req0_y));
                        last_id = 1'b0;
                        phase   = P_EXEC;
                    end else if (req1_valid && req1_ready) begin
                        sb.push_back(ref_op(1'b1, req1_op, req1_x, req1_y));
                        last_id = 1'b1;
                        phase   = P_EXEC;
                    end
                end
                P_EXEC: phase = P_RESP;
                default: begin
                    if (rsp_valid && rsp_ready) begin
                        if (sb.size() != 0) void'(sb.pop_front());
                        if (ref_cnt < 255) ref_cnt++;
                        n_ops++;
                        phase = P_IDLE;
                    end
                end
            endcase
        end
    end

    always begin
        @(posedge clk);
        #1;
        case (rr_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = ($urandom_range(3) != 0);
            default: rsp_ready = 1'b0;
        endcase
    end

    task automatic drive_req(input int id, input logic v, input logic [2:0] op,
                             input logic [3:0] x, input logic [3:0] y);
        if (id == 0) begin
            req0_valid = v; req0_op = op; req0_x = x; req0_y = y;
        end else begin
            req1_valid = v; req1_op = op; req1_x = x; req1_y = y;
        end
    endtask

    task automatic new_req(input int id);
        drive_req(id, 1'b1, 3'($urandom_range(7)), 4'($urandom_range(15)), 4'($urandom_range(15)));
    endtask

    task automatic issue(input int id, input logic [2:0] op, input logic [3:0] x, input logic [3:0] y);
        logic got = 1'b0;
        @(posedge clk);
        #1;
        drive_req(id, 1'b1, op, x, y);
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            got = (id == 0) ? req0_ready : req1_ready;
        end
        if (!got) check("issue_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(phase == P_IDLE && !rsp_valid) && k < 100);
        if (k >= 100) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_random(input int max_cycles, input int min_ops,
                              input int p_new, input int p_drop);
        int start = n_ops;
        int cyc = 0;
        logic a0, a1;
        while ((n_ops - start) < min_ops && cyc < max_cycles) begin
            @(negedge clk);
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            @(posedge clk);
            #1;
            if (!req0_valid || a0) begin
                if (int'($urandom_range(99)) < p_new) new_req(0); else req0_valid = 1'b0;
            end else if (int'($urandom_range(99)) < p_drop) req0_valid = 1'b0;
            if (!req1_valid || a1) begin
                if (int'($urandom_range(99)) < p_new) new_req(1); else req1_valid = 1'b0;
            end else if (int'($urandom_range(99)) < p_drop) req1_valid = 1'b0;
            cyc++;
        end
        if ((n_ops - start) < min_ops) check("random_progress", 32'(n_ops - start), 32'(min_ops));
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive_req(0, 1'b0, 3'd0, 4'd0, 4'd0);
        drive_req(1, 1'b0, 3'd0, 4'd0, 4'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_rsp", 32'({rsp_valid, rsp_id, rsp_s, rsp_c, rsp_zero, rsp_overflow, rsp_err}), 32'd0);
        check("reset_cnt", 32'(done_cnt), 32'd0);

        issue(0, 3'b000, 4'd7, 4'd3);
        wait_idle();
        issue(1, 3'b001, 4'd5, 4'd5);
        wait_idle();
        issue(0, 3'b111, 4'd9, 4'd4);
        wait_idle();
        issue(1, 3'b011, 4'hC, 4'hA);
        wait_idle();

        rr_mode = 2;
        issue(0, 3'b010, 4'd3, 4'd4);
        repeat (8) @(posedge clk);
        rr_mode = 0;
        wait_idle();

        run_random(200, 4, 100, 0);
        wait_idle();
        rr_mode = 1;
        run_random(2000, 40, 70, 5);
        rr_mode = 0;
        wait_idle();

        issue(0, 3'b000, 4'd1, 4'd2);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_exec_valid", 32'(rsp_valid), 32'd0);
        check("rst_exec_cnt", 32'(done_cnt), 32'd0);
        check("rst_exec_pins", 32'({alu_select, alu_in_c, alu_x, alu_y}), 32'd0);

        rr_mode = 1;
        run_random(6000, 262, 90, 3);
        rr_mode = 0;
        wait_idle();
        check("cnt_saturated", 32'(done_cnt), 32'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
